// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;
  typedef enum logic [1:0] {
    RUN,
    MEM_WAIT,
    FAULT
  } state_t;

  localparam int WAIT_W = 16;
  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: ID sources against the destination of a load in EX.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs1,
  input  logic [4:0] i_id_rs2,
  input  logic       i_use_rs1,
  input  logic       i_use_rs2,
  input  logic       i_ex_memread,
  input  logic [4:0] i_ex_rd,
  output logic       o_lu
);
  logic w_hit1;
  logic w_hit2;

  assign w_hit1 = i_use_rs1 & (i_id_rs1 == i_ex_rd);
  assign w_hit2 = i_use_rs2 & (i_id_rs2 == i_ex_rd);
  assign o_lu = i_ex_memread & (i_ex_rd != REG_X0)
              & (w_hit1 | w_hit2);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: load-use, redirects, memory waits with watchdog,
// plus saturating stall and flush counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  import pipe_ctrl_pkg::*;

  localparam logic [WAIT_W-1:0] TO = WAIT_W'(TIMEOUT);

  state_t             r_state;
  state_t             w_next;
  logic [WAIT_W-1:0]  r_wait;
  logic [WAIT_W-1:0]  w_wait_nx;
  logic [CNT_W-1:0]   r_stall;
  logic [CNT_W-1:0]   r_flush;
  logic               r_timeout;
  logic               w_lu;
  logic               w_freeze;
  logic               w_stall;
  logic               w_redir;
  logic [4:0]         w_en;
  logic [2:0]         w_fl;

  hazard_detect u_hd (
    .i_id_rs1     (id_rs1),
    .i_id_rs2     (id_rs2),
    .i_use_rs1    (id_use_rs1),
    .i_use_rs2    (id_use_rs2),
    .i_ex_memread (ex_memread),
    .i_ex_rd      (ex_rd),
    .o_lu         (w_lu)
  );

  assign w_freeze = mem_req & ~mem_ready;

  // w_en = {pc, ifid, idex, exmem, memwb}; w_fl = {ifid, idex, memwb}
  always_comb begin
    w_en    = 5'b11111;
    w_fl    = 3'b000;
    w_stall = 1'b0;
    w_redir = 1'b0;
    priority case (1'b1)
      (r_state == FAULT): begin
        w_en = 5'b00000;
      end
      w_freeze: begin
        w_en    = 5'b00001;
        w_fl    = 3'b001;
        w_stall = 1'b1;
      end
      ex_redirect: begin
        w_fl    = 3'b110;
        w_redir = 1'b1;
      end
      w_lu: begin
        w_en    = 5'b00111;
        w_fl    = 3'b010;
        w_stall = 1'b1;
      end
      default: ;
    endcase
  end

  assign pc_en       = w_en[4] & rstn;
  assign ifid_en     = w_en[3] & rstn;
  assign idex_en     = w_en[2] & rstn;
  assign exmem_en    = w_en[1] & rstn;
  assign memwb_en    = w_en[0] & rstn;
  assign ifid_flush  = w_fl[2] & rstn;
  assign idex_flush  = w_fl[1] & rstn;
  assign memwb_flush = w_fl[0] & rstn;

  always_comb begin
    w_next    = r_state;
    w_wait_nx = r_wait;
    unique case (r_state)
      RUN: begin
        if (w_freeze) begin
          w_next    = MEM_WAIT;
          w_wait_nx = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!w_freeze) begin
          w_next    = RUN;
          w_wait_nx = '0;
        end else if (r_wait < TO) begin
          w_wait_nx = r_wait + WAIT_W'(1);
        end else begin
          w_next = FAULT;
        end
      end
      FAULT: ;
      default: begin
        w_next    = RUN;
        w_wait_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= RUN;
      r_wait    <= '0;
      r_stall   <= '0;
      r_flush   <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_wait    <= w_wait_nx;
      r_timeout <= r_timeout | (w_next == FAULT);
      if (w_stall && !(&r_stall))
        r_stall <= r_stall + CNT_W'(1);
      if (w_redir && !(&r_flush))
        r_flush <= r_flush + CNT_W'(1);
    end
  end

  assign mem_timeout  = r_timeout;
  assign stall_cycles = r_stall;
  assign flush_count  = r_flush;
endmodule
